tr_stepper_ctrl: RTL and testbench
==================================

Name: tr_stepper_ctrl

Overview:
Tracking-regulator block. It converts each ADC sample x into a stepper-motor drive: direction, enable, and a step pulse train. The step frequency rises linearly with the error |x - x0| inside a window [dx1, dx2] and saturates at F2 above it. Top = tracking/period calculator; the pulse generator is a sub-module.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz, used as the period dividend
X_W, 36, ADC sample width
N_W, 17, period (clock-count) width
L_SHIFT, 4, fixed-point scale of k (L = 2^L_SHIFT = 16)

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  asynchronous active-low reset
data_valid  in  1  sample strobe, one clk wide; x valid when high at posedge clk
tr_mode_enable  in  1  tracking permit
x  in  X_W  ADC sample, unsigned
x0  in  32  target position, unsigned
dx1  in  32  dead-band threshold (error below this = no motion)
dx2  in  32  saturation threshold, dx2 > dx1
F1  in  32  minimum step frequency in Hz; F1 >= 382
F2  in  32  maximum step frequency in Hz
k  in  32  slope in Hz per count, scaled by L
data_valid_trig  in  1  pulse-generator update strobe
drv_dir  out  1  1 when x > x0, else 0
drv_enable_SM  out  1  motor enable
N  out  N_W  step period in clk cycles
drv_step  out  1  step pulse train

Behaviour:
- Reset (async, rst=0): all outputs and internal registers are 0; the step counter is idle.
- On each clk with data_valid=1 and the calculator idle:
  - capture dx = |x - x0| (X_W+1-bit compare, absolute difference)
  - capture drv_dir = (x > x0)
- Samples arriving while the divider is busy are dropped.
- Enable decision, registered 1 cycle after capture:
  - tr_mode_enable=0 -> drv_enable_SM=0
  - dx < dx1 -> drv_enable_SM=0
  - otherwise drv_enable_SM=1
- tr_mode_enable=0 forces drv_enable_SM=0 combinationally-registered on the next clk, regardless of sample timing.
- Frequency:
  - dx >= dx2 -> f = F2
  - dx1 <= dx < dx2 -> f = F1 + (((dx-dx1)*k) >> L_SHIFT), clamped to at most F2
  - product width 64 bits, unsigned, truncating shift
- Period: N = floor(CLK_HZ / f), computed by an iterative restoring divider.
  - Latency: exactly N_W+1 = 18 clk from capture to N update.
  - The quotient saturates to 2^N_W-1 on overflow.
  - N is updated only when drv_enable_SM=1; it holds otherwise.
- Pulse generator:
  - Shadow registers {en, period} load from {drv_enable_SM, N} on any clk with data_valid_trig=1.
  - The counter counts 0..period-1 and reloads active values from the shadow registers only at count wrap or when idle.
  - drv_step=1 for count < period>>1, else 0 (50% duty, floor).
  - Active en=0 or period<2 -> counter idle at 0, drv_step=0.
  - Disable mid-period: the current period completes, then the counter goes idle. No runt pulses.
- Simultaneous data_valid and data_valid_trig: the shadow registers take the old (registered) outputs.

Optional Feature:
- Macro TR_STEP_COUNT_EN.
  - Defined: adds output step_pos (32-bit signed, reset 0). It changes by +1 on each drv_step rising edge when drv_dir=1, and by -1 when drv_dir=0. It wraps two's-complement.
  - Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package tr_pkg holds:
  - constants CLK_HZ, X_W, N_W, L_SHIFT
  - typedef period_t (N_W bits)
  - typedef freq_t (32 bits)
  - typedef sample_t (X_W bits)
- One sub-module, tr_pulse_gen: the shadow registers, period counter and drv_step. The top holds the error calc, frequency map and divider.

Test Plan:
- Enable and saturation: k=2304, F1=6000, F2=50000, dx1=250, dx2=555, x0=5; tr_mode_enable=0 with x=30000 every 5 clk.
  - While tr_mode_enable=0: drv_enable_SM=0 and drv_step stays 0.
  - After tr_mode_enable=1: drv_enable_SM=1, drv_dir=1, N=1000.
  - drv_step toggles with a 1000-clk period, high for 500 clk.
- Linear region: x=265 (dx=260) -> f=7440, N=6720, 18 clk after capture; step high for 3360 clk. x=255 (dx=250) -> N=8333.
- Dead band and direction: x=100 (dx=95) -> drv_enable_SM=0. The current step period finishes, then drv_step stays 0. x=0 with x0=300 (dx=300) -> drv_dir=0, enable=1.
- Shadow load: change N mid-period with data_valid_trig pulses -> the old period completes unchanged and the new period starts at wrap.
- Async reset mid-pulse: assert rst=0 while drv_step=1 -> drv_step, N, drv_enable_SM and drv_dir go to 0 immediately. After release, normal operation resumes on the next sample.
- TR_STEP_COUNT_EN: 10 steps with drv_dir=1, then 4 with drv_dir=0 -> step_pos=6.

Source files
------------

// File: rtl/tr_pkg.sv
// Shared constants and types for the tracking stepper controller.
package tr_pkg;
  localparam int unsigned CLK_HZ  = 50000000;
  localparam int          X_W     = 36;
  localparam int          N_W     = 17;
  localparam int          L_SHIFT = 4;

  typedef logic [N_W-1:0] period_t;
  typedef logic [31:0]    freq_t;
  typedef logic [X_W-1:0] sample_t;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DIV} div_st_e;
endpackage

// File: rtl/tr_pulse_gen.sv
// Step pulse generator: shadow {en, period}, free-running period counter, 50% duty step.
module tr_pulse_gen
  import tr_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    i_trig,
  input  logic    i_en,
  input  period_t i_period,
  output logic    o_step
);
  logic    r_sh_en, r_en;
  period_t r_sh_per, r_per, r_cnt;
  logic    w_run;

  assign w_run = r_en && (r_per >= period_t'(2));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sh_en  <= 1'b0;
      r_sh_per <= '0;
      r_en     <= 1'b0;
      r_per    <= '0;
      r_cnt    <= '0;
    end else begin
      if (i_trig) begin
        r_sh_en  <= i_en;
        r_sh_per <= i_period;
      end
      // Active settings change only at a period boundary, so no runt pulses.
      if (!w_run || (r_cnt == r_per - 1'b1)) begin
        r_en  <= r_sh_en;
        r_per <= r_sh_per;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_step = w_run && (r_cnt < (r_per >> 1));
endmodule

// File: rtl/tr_stepper_ctrl.sv
// Tracking regulator: error capture, frequency map, restoring period divider.
// Optional step position counter enabled by macro TR_STEP_COUNT_EN.
module tr_stepper_ctrl
  import tr_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             data_valid,
  input  logic             tr_mode_enable,
  input  logic [X_W-1:0]   x,
  input  logic [31:0]      x0,
  input  logic [31:0]      dx1,
  input  logic [31:0]      dx2,
  input  logic [31:0]      F1,
  input  logic [31:0]      F2,
  input  logic [31:0]      k,
  input  logic             data_valid_trig,
  output logic             drv_dir,
  output logic             drv_enable_SM,
  output logic [N_W-1:0]   N,
  output logic             drv_step
`ifdef TR_STEP_COUNT_EN
  ,
  output logic signed [31:0] step_pos
`endif
);
  localparam logic [31:0] C_DVD  = 32'(CLK_HZ);
  localparam logic [31:0] C_REM0 = C_DVD >> N_W;

  div_st_e r_st, w_st_nxt;
  sample_t r_dx;
  logic    r_dir, r_en, r_ovf;
  freq_t   r_div;
  logic [31:0] r_rem;
  logic [4:0]  r_cnt;
  period_t r_q, r_n;

  logic    w_gt, w_ge;
  sample_t w_dx, w_dxd;
  logic [63:0] w_prod, w_lin;
  freq_t   w_f;
  logic [32:0] w_sh;
  logic [31:0] w_rem_nxt;
  period_t w_q_nxt;

  assign w_gt = x > sample_t'(x0);
  assign w_dx = w_gt ? (x - sample_t'(x0)) : (sample_t'(x0) - x);

  assign w_dxd  = r_dx - sample_t'(dx1);
  assign w_prod = 64'(w_dxd) * 64'(k);
  assign w_lin  = 64'(F1) + (w_prod >> L_SHIFT);
  assign w_f    = (r_dx >= sample_t'(dx2)) ? F2 :
                  (w_lin > 64'(F2))        ? F2 : w_lin[31:0];

  // One quotient bit per cycle; rem starts at the dividend bits above N_W.
  assign w_sh      = {r_rem, C_DVD[r_cnt]};
  assign w_ge      = w_sh >= {1'b0, r_div};
  assign w_rem_nxt = w_ge ? (w_sh[31:0] - r_div) : w_sh[31:0];
  assign w_q_nxt   = (r_q << 1) | period_t'(w_ge);

  always_comb begin
    w_st_nxt = r_st;
    case (r_st)
      S_IDLE:  if (data_valid) w_st_nxt = S_LOAD;
      S_LOAD:  w_st_nxt = S_DIV;
      S_DIV:   if (r_cnt == '0) w_st_nxt = S_IDLE;
      default: w_st_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_st <= S_IDLE;
    else      r_st <= w_st_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dx  <= '0;
      r_dir <= 1'b0;
      r_en  <= 1'b0;
      r_ovf <= 1'b0;
      r_div <= '0;
      r_rem <= '0;
      r_cnt <= '0;
      r_q   <= '0;
      r_n   <= '0;
    end else begin
      if (r_st == S_IDLE && data_valid) begin
        r_dx  <= w_dx;
        r_dir <= w_gt;
      end
      if (r_st == S_LOAD) begin
        r_div <= w_f;
        r_ovf <= C_REM0 >= w_f;
        r_rem <= C_REM0;
        r_cnt <= 5'(N_W - 1);
        r_q   <= '0;
      end
      if (r_st == S_DIV) begin
        r_rem <= w_rem_nxt;
        r_q   <= w_q_nxt;
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == '0 && r_en) r_n <= r_ovf ? '1 : w_q_nxt;
      end
      if (!tr_mode_enable)     r_en <= 1'b0;
      else if (r_st == S_LOAD) r_en <= (r_dx >= sample_t'(dx1));
    end
  end

  assign drv_dir       = r_dir;
  assign drv_enable_SM = r_en;
  assign N             = r_n;

  tr_pulse_gen u_pgen (
    .clk      (clk),
    .rst      (rst),
    .i_trig   (data_valid_trig),
    .i_en     (r_en),
    .i_period (r_n),
    .o_step   (drv_step)
  );

`ifdef TR_STEP_COUNT_EN
  logic               r_step_d;
  logic signed [31:0] r_pos;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_step_d <= 1'b0;
      r_pos    <= '0;
    end else begin
      r_step_d <= drv_step;
      if (drv_step && !r_step_d) r_pos <= r_dir ? r_pos + 32'sd1 : r_pos - 32'sd1;
    end
  end

  assign step_pos = r_pos;
`endif
endmodule

// File: tb/tb_tr_stepper_ctrl.sv
// Directed bench for tr_stepper_ctrl; step_pos checks compiled in with TR_STEP_COUNT_EN.
module tb_tr_stepper_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        data_valid = 1'b0, tr_mode_enable = 1'b0, data_valid_trig = 1'b0;
  logic [35:0] x = '0;
  logic [31:0] x0 = '0, dx1 = '0, dx2 = '0, F1 = '0, F2 = '0, k = '0;
  logic        drv_dir, drv_enable_SM, drv_step;
  logic [16:0] N;
`ifdef TR_STEP_COUNT_EN
  logic signed [31:0] step_pos;
`endif

  int n_chk = 0;
  int n_err = 0;

  tr_stepper_ctrl dut (
    .clk(clk), .rst(rst), .data_valid(data_valid), .tr_mode_enable(tr_mode_enable),
    .x(x), .x0(x0), .dx1(dx1), .dx2(dx2), .F1(F1), .F2(F2), .k(k),
    .data_valid_trig(data_valid_trig), .drv_dir(drv_dir), .drv_enable_SM(drv_enable_SM),
    .N(N), .drv_step(drv_step)
`ifdef TR_STEP_COUNT_EN
    , .step_pos(step_pos)
`endif
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Capture lands on the posedge after the first negedge; N is checked one clk before and at 18 clk.
  task automatic send_sample(input string tag, input logic [35:0] xv, input bit inj,
                             input logic exp_dir, input logic exp_en,
                             input logic [16:0] exp_old, input logic [16:0] exp_n);
    @(negedge clk); x = xv; data_valid = 1'b1;
    @(negedge clk); data_valid = 1'b0;
    chk({tag, "_dir"}, drv_dir, exp_dir);
    @(negedge clk);
    chk({tag, "_en"}, drv_enable_SM, exp_en);
    if (inj) begin
      x = 36'd30000; data_valid = 1'b1;
      @(negedge clk); data_valid = 1'b0;
    end else begin
      @(negedge clk);
    end
    repeat (15) @(negedge clk);
    chk({tag, "_n17"}, N, exp_old);
    @(negedge clk);
    chk({tag, "_n18"}, N, exp_n);
  endtask

  task automatic trig();
    @(negedge clk); data_valid_trig = 1'b1;
    @(negedge clk); data_valid_trig = 1'b0;
  endtask

  task automatic wait_rise(input string tag, output int n);
    logic prev;
    bit   tmo;
    n = 0; tmo = 1'b1; prev = drv_step;
    while (n < 20000) begin
      @(negedge clk); n++;
      if (!prev && drv_step) begin tmo = 1'b0; break; end
      prev = drv_step;
    end
    chk({tag, "_tmo"}, 64'(tmo), 64'd0);
  endtask

  // Called at the first high negedge of a period; ends at the next period's first negedge.
  task automatic measure(output int hi, output int per);
    int lo;
    hi = 0; lo = 0;
    while (drv_step && hi < 20000) begin hi++; @(negedge clk); end
    while (!drv_step && lo < 20000) begin lo++; @(negedge clk); end
    per = hi + lo;
  endtask

  initial begin
    int n, hi, per, bad;

    #5;
    chk("rst_step", drv_step, 1'b0);
    chk("rst_n", N, 17'd0);
    chk("rst_en", drv_enable_SM, 1'b0);
    chk("rst_dir", drv_dir, 1'b0);
    @(negedge clk); rst = 1'b1;

    k = 32'd2304; F1 = 32'd6000; F2 = 32'd50000; dx1 = 32'd250; dx2 = 32'd555; x0 = 32'd5;

    // Tracking not permitted: samples and triggers must produce no motion.
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); x = 36'd30000; data_valid = 1'b1; data_valid_trig = 1'b1;
      if (drv_step || drv_enable_SM) bad++;
      @(negedge clk); data_valid = 1'b0; data_valid_trig = 1'b0;
      repeat (3) begin @(negedge clk); if (drv_step || drv_enable_SM) bad++; end
    end
    chk("dis_motion", bad, 0);
    chk("dis_n", N, 17'd0);
    repeat (20) @(negedge clk);

    // Saturation: F2 = 50 kHz -> 1000 clk.
    tr_mode_enable = 1'b1;
    send_sample("sat", 36'd30000, 1'b0, 1'b1, 1'b1, 17'd0, 17'd1000);
    trig();
    wait_rise("sat_r", n);
    measure(hi, per);
    chk("sat_hi", hi, 500);
    chk("sat_per", per, 1000);

    // Linear: dx=260 -> f=7440 -> 6720; new period only after the running one wraps.
    send_sample("lin", 36'd265, 1'b0, 1'b1, 1'b1, 17'd1000, 17'd6720);
    wait_rise("sync1", n);
    repeat (100) @(negedge clk);
    data_valid_trig = 1'b1;
    @(negedge clk); data_valid_trig = 1'b0;
    wait_rise("shadow", n);
    chk("shadow_gap", n, 899);
    measure(hi, per);
    chk("lin_hi", hi, 3360);
    chk("lin_per", per, 6720);

    // dx == dx1 boundary -> f=F1; a sample offered while busy is dropped.
    send_sample("dx1", 36'd255, 1'b1, 1'b1, 1'b1, 17'd6720, 17'd8333);

    // Dead band: enable drops, N holds, running period finishes whole then idle.
    send_sample("dead", 36'd100, 1'b0, 1'b1, 1'b0, 17'd8333, 17'd8333);
    wait_rise("sync2", n);
    data_valid_trig = 1'b1;
    @(negedge clk); data_valid_trig = 1'b0;
    hi = 0;
    while (drv_step && hi < 20000) begin hi++; @(negedge clk); end
    chk("dead_hi", hi, 3359);
    bad = 0;
    repeat (8000) begin @(negedge clk); if (drv_step) bad++; end
    chk("dead_idle", bad, 0);

    // Negative direction: x=0, x0=300, dx=300 -> f=13200 -> 3787.
    x0 = 32'd300;
    send_sample("neg", 36'd0, 1'b0, 1'b0, 1'b1, 17'd8333, 17'd3787);

    // Async reset while the step is high.
    trig();
    wait_rise("sync3", n);
    repeat (10) @(negedge clk);
    chk("pre_rst_step", drv_step, 1'b1);
    rst = 1'b0;
    #1;
    chk("arst_step", drv_step, 1'b0);
    chk("arst_n", N, 17'd0);
    chk("arst_en", drv_enable_SM, 1'b0);
    chk("arst_dir", drv_dir, 1'b0);
    @(negedge clk); rst = 1'b1;
    send_sample("post", 36'd0, 1'b0, 1'b0, 1'b1, 17'd0, 17'd3787);
    trig();
    wait_rise("post_r", n);
    measure(hi, per);
    chk("post_hi", hi, 1893);
    chk("post_per", per, 3787);

    // Dropping the tracking permit clears enable on the next clk.
    @(negedge clk); tr_mode_enable = 1'b0;
    @(negedge clk);
    chk("force_off", drv_enable_SM, 1'b0);
    tr_mode_enable = 1'b1;

`ifdef TR_STEP_COUNT_EN
    rst = 1'b0;
    #1;
    chk("pos_rst", step_pos, 32'd0);
    @(negedge clk); rst = 1'b1;
    x0 = 32'd5;
    send_sample("pos_a", 36'd30000, 1'b0, 1'b1, 1'b1, 17'd0, 17'd1000);
    trig();
    for (int i = 0; i < 10; i++) wait_rise("pos_up", n);
    repeat (300) @(negedge clk);
    chk("pos_10", step_pos, 32'd10);
    x0 = 32'd300;
    send_sample("pos_b", 36'd0, 1'b0, 1'b0, 1'b1, 17'd1000, 17'd3787);
    for (int i = 0; i < 4; i++) wait_rise("pos_dn", n);
    repeat (5) @(negedge clk);
    chk("pos_6", step_pos, 32'd6);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
